// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl
//   Data-memory responder for the MEM stage. Single-word Rd/Wr requests are
//   served from a direct-mapped, write-back, write-allocate cache of one-word
//   lines. Misses go to a multi-cycle backing memory over a mem_rd/mem_wr +
//   mem_ready handshake.
//
//   Optional build macro: CACHE_STATS_EN adds saturating hit/miss counters.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   addr_i              request byte address (bit 0 must be 0)
//   data_in_i           store data
//   rd_i, wr_i          load / store request, held stable while stall_o=1
//   createdump_i        halt indication, accepted and ignored
//   data_out_o          load data, valid with done_o for a load
//   done_o              one-cycle completion pulse
//   stall_o             request accepted but not yet complete
//   cache_hit_o         qualifies done_o: no backing-memory access needed
//   err_o               illegal request (Rd&Wr, or unaligned access)
//   mem_addr_o          backing-memory address (word aligned)
//   mem_wdata_o         write-back data
//   mem_rd_o, mem_wr_o  fill / write-back request, held until mem_ready_i
//   mem_rdata_i         fill data, valid with mem_ready_i
//   mem_ready_i         backing memory completes the current access
//   hit_count_o         (CACHE_STATS_EN) completed hits, saturating
//   miss_count_o        (CACHE_STATS_EN) completed misses, saturating
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accept requests; hits complete in the same cycle
// EVICT | write dirty victim back, wait for mem_ready_i
// FILL  | read missing word from backing memory, wait for mem_ready_i
// RESP  | one-cycle miss completion; write misses install the line here

module dm_cache_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       data_in_i,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic              createdump_i,
    output logic [15:0]       data_out_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              cache_hit_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    input  logic [15:0]       mem_rdata_i,
    input  logic              mem_ready_i
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count_o,
    output logic [15:0]       miss_count_o
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - 1 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVICT,
        S_FILL,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [15:0]        data_q [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  req;
    logic                  illegal;
    logic                  hit;
    logic                  unused_inputs;

    assign idx     = addr_i[INDEX_BITS:1];
    assign tag     = addr_i[ADDR_W-1:INDEX_BITS+1];
    assign req     = rd_i | wr_i;
    assign illegal = (rd_i & wr_i) | (req & addr_i[0]);
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);

    // Halt indication has no effect on this block.
    assign unused_inputs = createdump_i;

    // Outputs depend on the request inputs because hits resolve in IDLE
    // within the same cycle.
    always_comb begin
        data_out_o  = '0;
        done_o      = 1'b0;
        stall_o     = 1'b0;
        cache_hit_o = 1'b0;
        err_o       = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (illegal) begin
                    err_o = 1'b1;
                end else if (req) begin
                    if (hit) begin
                        done_o      = 1'b1;
                        cache_hit_o = 1'b1;
                        if (rd_i) begin
                            data_out_o = data_q[idx];
                        end
                    end else begin
                        stall_o = 1'b1;
                    end
                end
            end
            S_EVICT: begin
                stall_o     = 1'b1;
                mem_wr_o    = 1'b1;
                mem_addr_o  = {tag_q[idx], idx, 1'b0};
                mem_wdata_o = data_q[idx];
            end
            S_FILL: begin
                stall_o    = 1'b1;
                mem_rd_o   = 1'b1;
                mem_addr_o = {addr_i[ADDR_W-1:1], 1'b0};
            end
            S_RESP: begin
                done_o = 1'b1;
                if (rd_i) begin
                    data_out_o = data_q[idx];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req && !illegal) begin
                        if (hit) begin
                            if (wr_i) begin
                                dirty_q[idx] <= 1'b1;
                            end
                        end else if (valid_q[idx] && dirty_q[idx]) begin
                            state_q <= S_EVICT;
                        end else if (rd_i) begin
                            state_q <= S_FILL;
                        end else begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_EVICT: begin
                    if (mem_ready_i) begin
                        state_q <= rd_i ? S_FILL : S_RESP;
                    end
                end
                S_FILL: begin
                    if (mem_ready_i) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (wr_i) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag/data storage needs no reset; valid_q guards every use.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == S_IDLE && req && !illegal && hit && wr_i) begin
                data_q[idx] <= data_in_i;
            end else if (state_q == S_FILL && mem_ready_i) begin
                data_q[idx] <= mem_rdata_i;
                tag_q[idx]  <= tag;
            end else if (state_q == S_RESP && wr_i) begin
                data_q[idx] <= data_in_i;
                tag_q[idx]  <= tag;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (done_o) begin
            if (cache_hit_o) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Testbench for dm_cache_ctrl: directed scenarios plus a randomized request
// stream, all checked against a line-level reference model of the cache and
// a word array standing in for the backing memory.

module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] din;
    logic        rd;
    logic        wr;
    logic        createdump;
    logic [15:0] data_out;
    logic        done;
    logic        stall;
    logic        cache_hit;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [15:0] bmem    [0:32767];
    bit          m_valid [0:15];
    bit          m_dirty [0:15];
    logic [10:0] m_tag   [0:15];
    logic [15:0] m_data  [0:15];

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .addr_i       (addr),
        .data_in_i    (din),
        .rd_i         (rd),
        .wr_i         (wr),
        .createdump_i (createdump),
        .data_out_o   (data_out),
        .done_o       (done),
        .stall_o      (stall),
        .cache_hit_o  (cache_hit),
        .err_o        (err),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rd_o     (mem_rd),
        .mem_wr_o     (mem_wr),
        .mem_rdata_i  (mem_rdata),
        .mem_ready_i  (mem_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
`endif
    );

    task automatic reset_model();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Issue one legal request, play the backing memory with 'dly' wait cycles
    // per access, and compare everything observed with the model.
    task automatic do_req(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d_in, input int dly, input string name);
        logic [3:0]  idx;
        logic [10:0] tg;
        bit          hit_e, ev_e, fill_e;
        int          exp_cyc, exp_rdc, exp_wrc;
        logic [15:0] exp_rdata, ev_addr_e, ev_data_e;
        int          cyc, busy, stall_n, rdc, wrc, both, excl;
        bit          done_seen;
        logic        hit_obs, err_obs;
        logic [15:0] dout_obs, ev_addr_obs, ev_data_obs, fill_addr_obs;

        idx       = a[4:1];
        tg        = a[15:5];
        hit_e     = m_valid[idx] && (m_tag[idx] == tg);
        ev_e      = !hit_e && m_valid[idx] && m_dirty[idx];
        fill_e    = !hit_e && r;
        ev_addr_e = {m_tag[idx], idx, 1'b0};
        ev_data_e = m_data[idx];
        exp_rdc   = fill_e ? dly + 1 : 0;
        exp_wrc   = ev_e ? dly + 1 : 0;
        exp_cyc   = hit_e ? 1 : 2 + exp_rdc + exp_wrc;
        exp_rdata = hit_e ? m_data[idx] : bmem[a[15:1]];

        @(negedge clk);
        rd = r; wr = w; addr = a; din = d_in; mem_ready = 1'b0;
        cyc = 0; busy = 0; stall_n = 0; rdc = 0; wrc = 0; both = 0; excl = 0;
        done_seen = 1'b0; hit_obs = 1'bx; err_obs = 1'bx; dout_obs = 'x;
        ev_addr_obs = 'x; ev_data_obs = 'x; fill_addr_obs = 'x;
        while (!done_seen && cyc < 60) begin
            #1;
            cyc++;
            if (mem_rd && mem_wr) both++;
            if (done && stall) excl++;
            if (stall) stall_n++;
            if (mem_rd) begin rdc++; fill_addr_obs = mem_addr; end
            if (mem_wr) begin wrc++; ev_addr_obs = mem_addr; ev_data_obs = mem_wdata; end
            if (mem_rd || mem_wr) begin
                if (busy == dly) begin
                    mem_ready = 1'b1;
                    if (mem_rd) mem_rdata = bmem[mem_addr[15:1]];
                end else begin
                    busy++;
                end
            end
            if (done) begin
                done_seen = 1'b1;
                hit_obs   = cache_hit;
                dout_obs  = data_out;
                err_obs   = err;
            end else begin
                @(negedge clk);
                if (mem_ready) begin
                    mem_ready = 1'b0;
                    busy      = 0;
                end
                mem_rdata = 16'($urandom);
            end
        end

        n_checks++;
        if (!done_seen) begin
            n_fail++; $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
        end
        n_checks++;
        if (cyc !== exp_cyc) begin
            n_fail++; $display("FAIL %s latency: got %0d exp %0d", name, cyc, exp_cyc);
        end
        n_checks++;
        if (stall_n !== exp_cyc - 1) begin
            n_fail++; $display("FAIL %s stall_cycles: got %0d exp %0d", name, stall_n, exp_cyc - 1);
        end
        n_checks++;
        if (rdc !== exp_rdc) begin
            n_fail++; $display("FAIL %s mem_rd_cycles: got %0d exp %0d", name, rdc, exp_rdc);
        end
        n_checks++;
        if (wrc !== exp_wrc) begin
            n_fail++; $display("FAIL %s mem_wr_cycles: got %0d exp %0d", name, wrc, exp_wrc);
        end
        n_checks++;
        if (both !== 0 || excl !== 0) begin
            n_fail++; $display("FAIL %s exclusivity: rd&wr=%0d done&stall=%0d exp 0", name, both, excl);
        end
        n_checks++;
        if (hit_obs !== hit_e) begin
            n_fail++; $display("FAIL %s cache_hit: got %b exp %b", name, hit_obs, hit_e);
        end
        n_checks++;
        if (err_obs !== 1'b0) begin
            n_fail++; $display("FAIL %s err: got %b exp 0", name, err_obs);
        end
        if (r) begin
            n_checks++;
            if (dout_obs !== exp_rdata) begin
                n_fail++; $display("FAIL %s data_out: got %h exp %h", name, dout_obs, exp_rdata);
            end
        end
        if (ev_e) begin
            n_checks++;
            if (ev_addr_obs !== ev_addr_e || ev_data_obs !== ev_data_e) begin
                n_fail++; $display("FAIL %s evict: got %h/%h exp %h/%h",
                                   name, ev_addr_obs, ev_data_obs, ev_addr_e, ev_data_e);
            end
        end
        if (fill_e) begin
            n_checks++;
            if (fill_addr_obs !== {a[15:1], 1'b0}) begin
                n_fail++; $display("FAIL %s fill_addr: got %h exp %h", name, fill_addr_obs, {a[15:1], 1'b0});
            end
        end

        if (hit_e) begin
            if (w) begin
                m_data[idx]  = d_in;
                m_dirty[idx] = 1'b1;
            end
        end else begin
            if (ev_e) bmem[ev_addr_e[15:1]] = ev_data_e;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = w ? d_in : bmem[a[15:1]];
            m_dirty[idx] = w;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'($urandom) & 16'hFFFE;
        din = 16'($urandom); createdump = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rd = 1'b0;
        #1;
        n_checks++;
        if ({done, stall, cache_hit, err, mem_rd, mem_wr} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b exp 000000", {done, stall, cache_hit, err, mem_rd, mem_wr});
        end
        n_checks++;
        if (data_out !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            n_fail++; $display("FAIL reset_buses: got %h/%h/%h exp 0/0/0", data_out, mem_addr, mem_wdata);
        end
        reset_model();
    endtask

    task automatic test_read_miss_hit();
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, 0, "rd_miss_0010");
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, 0, "rd_hit_0010");
    endtask

    task automatic test_dirty_evict();
        do_req(1'b0, 1'b1, 16'h0010, 16'h1234, 0, "wr_hit_0010");
        do_req(1'b1, 1'b0, 16'h0030, 16'h0, 0, "rd_evict_0030");
    endtask

    task automatic test_write_miss();
        do_req(1'b0, 1'b1, 16'h0042, 16'h00AA, 0, "wr_miss_0042");
        do_req(1'b1, 1'b0, 16'h0042, 16'h0, 0, "rd_hit_0042");
    endtask

    task automatic test_slow_fill();
        do_req(1'b1, 1'b0, 16'h0100, 16'h0, 4, "rd_slow_fill");
    endtask

    task automatic test_err();
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = 16'h0010;
        #1;
        n_checks++;
        if ({err, done, stall, mem_rd, mem_wr} !== 5'b10000) begin
            n_fail++; $display("FAIL err_rdwr: got %b exp 10000", {err, done, stall, mem_rd, mem_wr});
        end
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 16'h0003;
        #1;
        n_checks++;
        if ({err, done, stall, mem_rd, mem_wr} !== 5'b10000) begin
            n_fail++; $display("FAIL err_unaligned: got %b exp 10000", {err, done, stall, mem_rd, mem_wr});
        end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        #1;
        n_checks++;
        if ({err, done, stall, mem_rd, mem_wr} !== 5'b00000) begin
            n_fail++; $display("FAIL err_idle_after: got %b exp 00000", {err, done, stall, mem_rd, mem_wr});
        end
        do_req(1'b1, 1'b0, 16'h0042, 16'h0, 0, "rd_after_err");
    endtask

    task automatic test_reset_mid_fill();
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, 0, "rd_prefetch_0010");
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 16'hFFF0; mem_ready = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL midfill_stall: got %b exp 1", stall);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'hFFF0) begin
            n_fail++; $display("FAIL midfill_fill: got %b/%h exp 1/fff0", mem_rd, mem_addr);
        end
        rst = 1'b1; rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_rd, mem_wr, stall, done} !== 4'b0000) begin
            n_fail++; $display("FAIL midfill_after_rst: got %b exp 0000", {mem_rd, mem_wr, stall, done});
        end
        reset_model();
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, 0, "reread_after_rst");
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic        r;
        for (int i = 0; i < 200; i++) begin
            r = 1'($urandom_range(0, 1));
            a = {11'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b0};
            do_req(r, !r, a, 16'($urandom), $urandom_range(0, 3), "random");
        end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) bmem[i] = 16'($urandom);
        bmem[16'h0010 >> 1] = 16'hBEEF;
        reset_model();
        test_reset();
        test_read_miss_hit();
        test_dirty_evict();
        test_write_miss();
        test_slow_fill();
        test_err();
        test_reset_mid_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
